imul_seq_multiplier: RTL

//  Parametrised iterative shift-add integer multiplier; successor to the fixed 4x4 combinational IMUL array.

---
 rtl/imul_seq_multiplier_pkg.sv | 15 +
 rtl/imul_add_shift_stage.sv | 25 ++
 rtl/imul_seq_multiplier.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/imul_seq_multiplier_pkg.sv
// Shared definitions for the iterative IMUL unit:
// opcode, FSM state encodings and default operand width.
package imul_seq_multiplier_pkg;

    localparam int IMUL_DEFAULT_WIDTH = 8;

    localparam logic [3:0] IMUL_OPCODE = 4'hC;

    typedef enum logic [1:0] {
        IMUL_ST_IDLE = 2'd0,
        IMUL_ST_RUN  = 2'd1,
        IMUL_ST_DONE = 2'd2
    } imul_state_t;

endpackage

// File: rtl/imul_add_shift_stage.sv
// One shift-add step: conditional add of mcand into acc_hi,
// then {carry,acc_hi,mplr} shifted right by one bit.
module imul_add_shift_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplr,
    output logic [WIDTH-1:0] o_acc_hi,
    output logic [WIDTH-1:0] o_mplr
);

    logic [WIDTH:0] w_sum;

    // WIDTH+1-bit sum keeps the carry for the shift
    always_comb begin
        w_sum = {1'b0, i_acc_hi};
        if (i_mplr[0]) begin
            w_sum = {1'b0, i_acc_hi} + {1'b0, i_mcand};
        end
        o_acc_hi = w_sum[WIDTH:1];
        o_mplr   = {w_sum[0], i_mplr[WIDTH-1:1]};
    end

endmodule

// File: rtl/imul_seq_multiplier.sv
// Iterative shift-add multiplier, WIDTH cycles per product.
// Optional two's-complement mode when IMUL_SIGNED_EN is defined.
module imul_seq_multiplier
    import imul_seq_multiplier_pkg::*;
#(
    parameter  int WIDTH = IMUL_DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
`ifdef IMUL_SIGNED_EN
    input  logic               iSigned,
`endif
    output logic               oBusy,
    output logic               oDone,
    output logic [2*WIDTH-1:0] oResult
);

    imul_state_t r_state;
    imul_state_t w_next_state;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mplr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_mplr_nxt;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_final;

    assign w_prod = {r_acc, r_mplr};

`ifdef IMUL_SIGNED_EN
    logic r_neg;

    // -2^(W-1) negates to itself, read as unsigned 2^(W-1)
    assign w_a_mag = (iSigned && iA[WIDTH-1]) ? (~iA + WIDTH'(1)) : iA;
    assign w_b_mag = (iSigned && iB[WIDTH-1]) ? (~iB + WIDTH'(1)) : iB;
    assign w_final = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;

    // Result sign captured with the operands
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_neg <= 1'b0;
        end else if (r_state == IMUL_ST_IDLE && iStart) begin
            r_neg <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
        end
    end
`else
    assign w_a_mag = iA;
    assign w_b_mag = iB;
    assign w_final = w_prod;
`endif

    imul_add_shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .i_acc_hi (r_acc),
        .i_mcand  (r_mcand),
        .i_mplr   (r_mplr),
        .o_acc_hi (w_acc_nxt),
        .o_mplr   (w_mplr_nxt)
    );

    // FSM state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IMUL_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and busy flag
    always_comb begin
        w_next_state = r_state;
        oBusy        = 1'b0;
        unique case (r_state)
            IMUL_ST_IDLE: begin
                if (iStart) begin
                    w_next_state = IMUL_ST_RUN;
                end
            end
            IMUL_ST_RUN: begin
                oBusy = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next_state = IMUL_ST_DONE;
                end
            end
            IMUL_ST_DONE: begin
                oBusy        = 1'b1;
                w_next_state = IMUL_ST_IDLE;
            end
            default: begin
                w_next_state = IMUL_ST_IDLE;
            end
        endcase
    end

    // Operand capture, iteration and result latch
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplr   <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IMUL_ST_IDLE: begin
                    if (iStart) begin
                        r_mcand <= w_a_mag;
                        r_mplr  <= w_b_mag;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                IMUL_ST_RUN: begin
                    r_acc  <= w_acc_nxt;
                    r_mplr <= w_mplr_nxt;
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                IMUL_ST_DONE: begin
                    r_result <= w_final;
                    r_done   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign oDone   = r_done;
    assign oResult = r_result;

endmodule
